// File: rtl/square_motion_ctrl.sv
// square_motion_ctrl: debounced, accelerating, clamped per-frame position of the player square
// Ports: vga_clk/reset (sync, active-high); left/right/up/down raw buttons;
//        vs active-low vertical sync; sq_x/sq_y registered top-left corner;
//        frame_tick one-cycle pulse per vs falling edge; moving = last tick changed a coordinate.
module square_motion_ctrl #(
  parameter int FIELD_W      = 480,
  parameter int FIELD_H      = 480,
  parameter int SIZE         = 32,
  parameter int STEP         = 4,
  parameter int ACCEL_FRAMES = 8,
  parameter int DEBOUNCE     = 250000,
  parameter int X0           = 224,
  parameter int Y0           = 224
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  input  logic       vs,
  output logic [9:0] sq_x,
  output logic [9:0] sq_y,
  output logic       frame_tick,
  output logic       moving
);
  localparam int CW = DEBOUNCE > 1 ? $clog2(DEBOUNCE) : 1;
  localparam int HW = $clog2(ACCEL_FRAMES + 1);
  typedef enum logic {IDLE, RUN} state_t;
  logic [3:0]    s1_q, s2_q, db_q, db_d, dbp_q;
  logic [CW-1:0] cnt_q [4], cnt_d [4];
  logic          vs_q, tick_q, tick_d, moving_q, moving_d;
  logic [1:0]    go, neg, dneg_q, dneg_d;
  state_t        st_q [2], st_d [2];
  logic [HW-1:0] hold_q [2], hold_d [2];
  logic [9:0]    pos_q [2], pos_d [2];
  logic [10:0]   step [2], lim [2], sum [2];
  // bit order: 0=left 1=right 2=up 3=down
  always_comb begin
    db_d = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++) begin
      db_d[i] = (s2_q[i] != db_q[i] && cnt_q[i] == CW'(DEBOUNCE - 1)) ? ~db_q[i] : db_q[i];
      cnt_d[i] = (s2_q[i] == db_q[i] || cnt_q[i] == CW'(DEBOUNCE - 1)) ? '0 : cnt_q[i] + CW'(1);
    end
  end
  // axes read the debounced state delayed one cycle, so a flip landing on the tick cycle waits a frame
  assign go  = {dbp_q[3] ^ dbp_q[2], dbp_q[1] ^ dbp_q[0]};
  assign neg = {dbp_q[2] & ~dbp_q[3], dbp_q[0] & ~dbp_q[1]};
  assign tick_d = vs_q & ~vs;
  always_comb begin
    st_d = st_q;
    hold_d = hold_q;
    dneg_d = dneg_q;
    pos_d = pos_q;
    for (int a = 0; a < 2; a++) begin
      lim[a] = a == 0 ? 11'(FIELD_W - SIZE) : 11'(FIELD_H - SIZE);
      step[a] = '0;
      sum[a] = '0;
      if (tick_q) begin
        if (!go[a]) begin
          st_d[a] = IDLE;
          hold_d[a] = '0;
        end else if (st_q[a] == IDLE || neg[a] != dneg_q[a]) begin
          st_d[a] = RUN;
          hold_d[a] = HW'(1);
          dneg_d[a] = neg[a];
        end else begin
          hold_d[a] = hold_q[a] == HW'(ACCEL_FRAMES) ? hold_q[a] : hold_q[a] + HW'(1);
        end
        step[a] = hold_d[a] < HW'(ACCEL_FRAMES) ? 11'(STEP) : 11'(2 * STEP);
        sum[a] = {1'b0, pos_q[a]} + step[a];
        if (go[a])
          pos_d[a] = neg[a] ? ({1'b0, pos_q[a]} >= step[a] ? pos_q[a] - step[a][9:0] : '0)
                            : (sum[a] > lim[a] ? lim[a][9:0] : sum[a][9:0]);
      end
    end
    moving_d = tick_q ? (pos_d[0] != pos_q[0] || pos_d[1] != pos_q[1]) : moving_q;
  end
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      db_q <= '0;
      dbp_q <= '0;
      vs_q <= 1'b1;
      tick_q <= 1'b0;
      moving_q <= 1'b0;
      dneg_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      for (int a = 0; a < 2; a++) begin
        st_q[a] <= IDLE;
        hold_q[a] <= '0;
      end
      pos_q[0] <= 10'(X0);
      pos_q[1] <= 10'(Y0);
    end else begin
      s1_q <= {down, up, right, left};
      s2_q <= s1_q;
      db_q <= db_d;
      dbp_q <= db_q;
      cnt_q <= cnt_d;
      vs_q <= vs;
      tick_q <= tick_d;
      moving_q <= moving_d;
      dneg_q <= dneg_d;
      st_q <= st_d;
      hold_q <= hold_d;
      pos_q <= pos_d;
    end
  end
  assign sq_x = pos_q[0];
  assign sq_y = pos_q[1];
  assign frame_tick = tick_q;
  assign moving = moving_q;
endmodule
